// File: rtl/keypad_scan_entry.sv
// -----------------------------------------------------------------------------
// keypad_scan_entry
//
// Scans a 4x4 hex matrix keypad one active-low column at a time and debounces
// each press. It emits one hex key code per accepted press and shifts every
// accepted digit into a 32-bit operand register for the ALU test top.
//
// Ports:
//   clock      system clock
//   rst        synchronous active-low reset, sampled on posedge clock
//   ROW[3:0]   keypad rows, active-low (pulled up); 0 = key pressed in row i
//   CLR        synchronous clear of VALUE, active-high
//   COL[3:0]   column drive, active-low, exactly one bit low
//   KEY_CODE   last accepted key, row_idx*4 + col_idx
//   KEY_VALID  one-cycle pulse when KEY_CODE updates
//   VALUE      accumulated hex entry, newest digit in the low nibble
//
// Optional feature:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key regenerates KEY_VALID every
//                         REPEAT_SCANS scan ticks. When undefined, a press gives
//                         exactly one KEY_VALID and REPEAT_SCANS has no effect.
// -----------------------------------------------------------------------------
module keypad_scan_entry #(
    parameter int SCAN_DIV       = 260000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [3:0]  ROW,
    input  logic        CLR,
    output logic [3:0]  COL,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_VALID,
    output logic [31:0] VALUE
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW = $clog2(REPEAT_SCANS + 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    // Bad parameter values stop elaboration instead of building a broken scanner.
    if (SCAN_DIV < 1 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
        $error("keypad_scan_entry: SCAN_DIV, DEBOUNCE_SCANS and REPEAT_SCANS must be >= 1");
    end

    logic [TW-1:0] tick_cnt;
    logic [1:0]    state, state_d;
    logic [1:0]    col_idx, col_d;
    logic [1:0]    row_idx, row_d;
    logic [DW-1:0] deb_cnt, deb_d;
    logic          accept;
    logic [1:0]    first_low;
    logic          any_low;
    logic          row_low;
    logic          tick;
    logic [3:0]    code;
    logic [31:0]   value_base;

    assign tick    = (tick_cnt == TW'(SCAN_DIV - 1));
    assign any_low = ~&ROW;
    // Only the latched row matters once a column is frozen; other keys are ignored.
    assign row_low = ~ROW[row_idx];
    assign code    = {row_d, col_idx};
    assign COL     = ~(4'b0001 << col_idx);

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!ROW[i]) first_low = 2'(i);
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [RW-1:0] rep_cnt, rep_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d = state;
        col_d   = col_idx;
        row_d   = row_idx;
        deb_d   = deb_cnt;
        accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        // The repeat count only survives while sitting in HELD.
        rep_d   = (state == S_HELD) ? rep_cnt : '0;
`endif
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (!any_low) begin
                        col_d = col_idx + 2'd1;
                    end else begin
                        row_d = first_low;
                        deb_d = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (row_low) begin
                        deb_d = deb_cnt + 1'b1;
                        if (deb_d == DW'(DEBOUNCE_SCANS)) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = S_SCAN;
                        col_d   = col_idx + 2'd1;
                    end
                end
                S_HELD: begin
                    if (!row_low) begin
                        deb_d = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_SCAN;
                            col_d   = col_idx + 2'd1;
                        end else begin
                            state_d = S_RELEASE;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
                    end else begin
                        rep_d = rep_cnt + 1'b1;
                        if (rep_d == RW'(REPEAT_SCANS)) begin
                            accept = 1'b1;
                            rep_d  = '0;
                        end
`endif
                    end
                end
                default: begin // S_RELEASE
                    if (!row_low) begin
                        deb_d = deb_cnt + 1'b1;
                        if (deb_d == DW'(DEBOUNCE_SCANS)) begin
                            state_d = S_SCAN;
                            col_d   = col_idx + 2'd1;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
    end

    // Clear applies before the new digit is inserted.
    assign value_base = CLR ? 32'h0 : VALUE;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            tick_cnt  <= '0;
            state     <= S_SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            deb_cnt   <= '0;
            KEY_CODE  <= 4'h0;
            KEY_VALID <= 1'b0;
            VALUE     <= 32'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            state     <= state_d;
            col_idx   <= col_d;
            row_idx   <= row_d;
            deb_cnt   <= deb_d;
            KEY_VALID <= accept;
            if (accept) begin
                KEY_CODE <= code;
                VALUE    <= {value_base[27:0], code};
            end else begin
                VALUE    <= value_base;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_entry
//
// Drives a behavioural 4x4 keypad (pressed-key map resolved against COL) into
// keypad_scan_entry with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2.
// Presses are aligned to the column slot, so the number of accepted pulses is
// known from the hold length alone; expected (code, value) pairs are queued
// when a press is issued and popped by an independent monitor on KEY_VALID.
// -----------------------------------------------------------------------------
module tb_keypad_scan_entry;

    localparam int SCAN_T = 4;
    localparam int DEB_T  = 3;
    localparam int REP_T  = 2;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] value;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst;
    logic [3:0]  ROW;
    logic        CLR;
    logic [3:0]  COL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic [31:0] VALUE;

    logic [15:0] pressed;      // bit r*4+c = key at row r, column c held down
    logic [31:0] model_value;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    keypad_scan_entry #(
        .SCAN_DIV      (SCAN_T),
        .DEBOUNCE_SCANS(DEB_T),
        .REPEAT_SCANS  (REP_T)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .ROW      (ROW),
        .CLR      (CLR),
        .COL      (COL),
        .KEY_CODE (KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .VALUE    (VALUE)
    );

    always #5 clock = ~clock;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!COL[c] && pressed[r*4+c]) ROW[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    // Monitor: every KEY_VALID cycle consumes one expected entry.
    always @(negedge clock) begin
        if (KEY_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: got code %h value %h expected no pulse (t=%0t)",
                         KEY_CODE, VALUE, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("key_code", {28'h0, KEY_CODE}, {28'h0, e.code});
                check("value_on_pulse", VALUE, e.value);
            end
        end
    end

    // Wait until COL has just switched to column c (right after the slot's tick edge).
    task automatic wait_col(input int c, output bit ok);
        logic [3:0] prev;
        int n;
        prev = COL;
        n = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clock);
            if (COL == col_pat(c) && prev != col_pat(c)) ok = 1'b1;
            prev = COL;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_col: column %0d never became active (COL=%b)", c, COL);
        end
    endtask

    // Press the keys of mask (all in column c) for low_ticks scan ticks, then release.
    task automatic press(input logic [15:0] mask, input int c, input int low_ticks, input bit clr_acc);
        bit ok;
        logic [3:0] code;
        int pulses;
        exp_t e;
        code = 4'h0;
        for (int r = 3; r >= 0; r--)
            if (mask[r*4+c]) code = 4'(r*4 + c);
        pulses = 0;
        if (low_ticks >= DEB_T) begin
            pulses = 1;
`ifdef KEYPAD_AUTOREPEAT_EN
            pulses += (low_ticks - DEB_T) / REP_T;
`endif
        end
        wait_col(c, ok);
        if (!ok) return;
        for (int p = 0; p < pulses; p++) begin
            if (p == 0 && clr_acc) model_value = {28'h0, code};
            else                   model_value = {model_value[27:0], code};
            e.code  = code;
            e.value = model_value;
            exp_q.push_back(e);
        end
        pressed = mask;
        if (clr_acc && low_ticks >= DEB_T) begin
            repeat (SCAN_T*DEB_T - 1) @(posedge clock);
            @(negedge clock) CLR = 1'b1;
            @(posedge clock);
            @(negedge clock) CLR = 1'b0;
            repeat (SCAN_T*(low_ticks - DEB_T)) @(posedge clock);
        end else begin
            repeat (SCAN_T*low_ticks) @(posedge clock);
        end
        @(negedge clock) pressed = 16'h0;
        repeat (SCAN_T) @(posedge clock);
        @(negedge clock);
        if (low_ticks >= DEB_T) begin
            check("col_frozen_release", {28'h0, COL}, {28'h0, col_pat(c)});
            repeat (SCAN_T*(DEB_T - 1)) @(posedge clock);
            @(negedge clock);
            check("col_after_release", {28'h0, COL}, {28'h0, col_pat((c + 1) % 4)});
        end else begin
            check("col_after_bounce", {28'h0, COL}, {28'h0, col_pat((c + 1) % 4)});
        end
        check("value_after_press", VALUE, model_value);
    endtask

    task automatic pulse_clr();
        @(negedge clock) CLR = 1'b1;
        @(posedge clock);
        @(negedge clock) CLR = 1'b0;
        model_value = 32'h0;
        check("value_after_clr", VALUE, 32'h0);
    endtask

    function automatic logic [15:0] key_bit(input int code);
        logic [15:0] one;
        one = 16'h1;
        return one << code;
    endfunction

    initial begin
        bit ok;
        pressed     = 16'h0;
        model_value = 32'h0;
        CLR         = 1'b0;
        rst         = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_col", {28'h0, COL}, 32'h0000_000E);
        check("rst_key_code", {28'h0, KEY_CODE}, 32'h0);
        check("rst_key_valid", {31'h0, KEY_VALID}, 32'h0);
        check("rst_value", VALUE, 32'h0);
        rst = 1'b1;

        // Idle scan: column advances every SCAN_T clocks.
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("idle_col", {28'h0, COL}, {28'h0, col_pat((k / SCAN_T) % 4)});
        end
        check("idle_value", VALUE, 32'h0);

        // Row 1 in column 2 held 6 ticks.
        press(key_bit(6), 2, 6, 1'b0);
        check("single_press_value", VALUE, 32'h0000_0006);

        // Bounce: two low ticks is one short of acceptance.
        press(key_bit(8), 0, 2, 1'b0);
        check("bounce_value", VALUE, 32'h0000_0006);

        // Keys 1..9: the oldest digits fall off the top.
        for (int k = 1; k <= 9; k++) press(key_bit(k), k % 4, DEB_T, 1'b0);
        check("nine_digit_value", VALUE, 32'h2345_6789);
        pulse_clr();

        // Rows 0 and 3 together in column 1: row 0 wins.
        press(key_bit(1) | key_bit(13), 1, DEB_T, 1'b0);
        check("multi_row_code", {28'h0, KEY_CODE}, 32'h1);

        // Reset in the middle of debouncing aborts the press.
        wait_col(2, ok);
        if (ok) begin
            pressed = key_bit(6);
            repeat (SCAN_T*2) @(posedge clock);
            @(negedge clock) begin rst = 1'b0; pressed = 16'h0; end
            @(posedge clock);
            @(negedge clock) rst = 1'b1;
            model_value = 32'h0;
            check("midrst_col", {28'h0, COL}, 32'h0000_000E);
            check("midrst_key_code", {28'h0, KEY_CODE}, 32'h0);
            check("midrst_key_valid", {31'h0, KEY_VALID}, 32'h0);
            check("midrst_value", VALUE, 32'h0);
            repeat (SCAN_T*6) @(posedge clock);
        end

        // Key A held 7 ticks beyond acceptance.
        press(key_bit(10), 2, DEB_T + 7, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_value", VALUE, 32'h0000_AAAA);
`else
        check("hold_value", VALUE, 32'h0000_000A);
`endif

        // Clear landing on the acceptance edge keeps only the new digit.
        press(key_bit(7), 3, DEB_T, 1'b1);
        check("clr_at_accept_value", VALUE, 32'h0000_0007);

        // Randomized presses, bounces, double-row presses and clears.
        for (int n = 0; n < 30; n++) begin
            int c, r, low;
            logic [15:0] mask;
            bit clr_acc;
            c    = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            mask = key_bit(r*4 + c);
            if ($urandom_range(0, 3) == 0) mask |= key_bit($urandom_range(0, 3)*4 + c);
            low     = $urandom_range(1, 7);
            clr_acc = (low >= DEB_T) && ($urandom_range(0, 5) == 0);
            press(mask, c, low, clr_acc);
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end

        repeat (10) @(posedge clock);
        @(negedge clock);
        check("pending_expected", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_scan_entry.md
Name: keypad_scan_entry

Overview:
Input-side counterpart to the board's multiplexed 7-segment display driver. It scans a 4x4 hex matrix keypad by driving one active-low column at a time, mirroring the digit-select scan on the display. It reads the active-low row lines and debounces each press, then emits one hex key code per press. Accepted digits are shifted into a 32-bit operand register that feeds the ALU test top in place of the fixed switch-selected operands.

Parameters:
SCAN_DIV, 260000, clock cycles per column slot; scan tick = counter reaching SCAN_DIV-1, then counter wraps to 0.
DEBOUNCE_SCANS, 4, consecutive matching ticks required to accept a press or a release (>=1).
REPEAT_SCANS, 64, ticks of continuous hold before auto-repeat (used only with the optional feature).

Ports:
clock  in  1  system clock.
rst  in  1  synchronous active-low reset, sampled on posedge clock.
ROW  in  4  keypad rows, active-low, externally pulled up; ROW[i]=0 means a key in row i of the driven column is pressed.
CLR  in  1  synchronous clear of VALUE, active-high.
COL  out  4  column drive, active-low, exactly one bit low: index 0..3 gives 4'b1110, 4'b1101, 4'b1011, 4'b0111.
KEY_CODE  out  4  last accepted key, code = row_idx*4 + col_idx.
KEY_VALID  out  1  one-cycle pulse when KEY_CODE updates.
VALUE  out  32  accumulated hex entry.

Behaviour:
- Reset (rst=0 at posedge): COL=4'b1110, KEY_CODE=0, KEY_VALID=0, VALUE=0, state=SCAN, tick counter=0, debounce counter=0. Reset mid-press aborts the press with no KEY_VALID.
- Tick counter free-runs in every state. ROW is sampled only on tick cycles, at the end of a column slot, which gives the lines settle time.
- Row priority: if more than one row is low, the lowest index wins.
- SCAN: on a tick with ROW==4'hF, advance column index (3 wraps to 0). On a tick with any row low, latch row_idx, freeze the column, set debounce count=1, and go to DEBOUNCE.
- DEBOUNCE: on each tick, if the latched row is still low, increment the count. When the count reaches DEBOUNCE_SCANS, go to HELD and, on the next clock edge, set KEY_VALID=1, update KEY_CODE, and set VALUE = {VALUE[27:0], code}. If the latched row is high on a tick, return to SCAN and advance the column with no output.
- With DEBOUNCE_SCANS=1, acceptance happens on the detecting tick itself.
- HELD: column stays frozen. A tick with the latched row high goes to RELEASE with count=1.
- RELEASE: a tick with the row high increments the count; reaching DEBOUNCE_SCANS returns to SCAN and advances the column. A tick with the row low returns to HELD with no new KEY_VALID.
- Keys in other columns are ignored while the column is frozen.
- KEY_VALID is high for exactly one clock per accepted press.
- VALUE overflow: after 8 digits, the oldest nibble is discarded. There is no saturation or flag.
- CLR: VALUE <= 0 on the next edge. If CLR coincides with a KEY_VALID update, VALUE = {28'h0, code}: the clear applies first, then the digit is inserted. KEY_CODE is unaffected by CLR.

Optional Feature:
Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks. Each time it reaches REPEAT_SCANS, it regenerates KEY_VALID with the same code, shifts VALUE again, and restarts the count. The counter clears on entry to HELD and in RELEASE.
- Undefined: exactly one KEY_VALID per press however long the key is held, and the REPEAT_SCANS parameter is unused.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Idle, ROW=4'hF after reset: COL cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks. KEY_VALID stays 0, VALUE=0.
- Press row1 while col2 is driven, held 6 ticks then released: one KEY_VALID pulse with KEY_CODE=4'h6 and VALUE=32'h0000_0006. COL stays 1011 until 3 released ticks have passed, then moves to 0111.
- Bounce: row low for 2 ticks then high: no KEY_VALID, VALUE unchanged, scanning resumes at the next column.
- Enter keys 1,2,3,4,5,6,7,8,9 in sequence: VALUE=32'h2345_6789 (nibble 1 shifted out). Then assert CLR with no key activity: VALUE=0.
- Rows 0 and 3 low together in col1: KEY_CODE=4'h1. Assert rst for one edge during DEBOUNCE: all outputs return to reset values and no pulse occurs.
- KEYPAD_AUTOREPEAT_EN defined, REPEAT_SCANS=2, key 4'hA held 7 ticks beyond acceptance: 4 total KEY_VALID pulses and VALUE=32'h0000_AAAA.
